// File: rtl/caleidoscope_sequencer.sv
// caleidoscope_sequencer
// ----------------------------------------------------------------------------
// Sequencing controller for the caleidoscope pixel datapath.
//
// The module works in the single clock domain CLK_25MHz. VBLANK and HBLANK are
// sampled as ordinary data, and their rising edges start two independent FSMs:
//   * frame FSM : once per frame it advances TIME, folds it into a triangle
//                 wave, and derives TIME_CONST. FRAME_TICK pulses for one
//                 cycle, together with the new TIME_CONST.
//   * line FSM  : once per scanline it folds CURY around the middle of the
//                 screen into NEW_Y and squares it with a 9-cycle shift-add
//                 multiplier. LINE_READY rises when the results commit.
//
// Ports
//   CLK_25MHz   in   1   pixel clock, the only clock
//   RESET       in   1   synchronous, active-high reset
//   VBLANK      in   1   vertical blank from vga_driver
//   HBLANK      in   1   horizontal blank from vga_driver
//   CURY        in   9   current line from vga_driver
//   SWITCH      in   3   [0] stop time, [1] 2x speed, [2] unlimited time
//   TIME        out 16   frame time counter
//   TIME_CONST  out 24   per-frame constant for the pixel stage
//   NEW_Y       out  9   folded row
//   Y_SQUARED   out 16   NEW_Y*NEW_Y
//   LINE_READY  out  1   NEW_Y/Y_SQUARED are valid for the current line
//   FRAME_TICK  out  1   one-cycle pulse when TIME_CONST updates
//   BUSY        out  1   multiplier running
//
// Build option
//   CALEIDOSCOPE_AUTOPLAY_EN : when this macro is defined, an 8-bit frame
//   counter drives the speed and limit modes, so the design cycles through
//   them every 64 frames. SWITCH[0] still stops time.
// ----------------------------------------------------------------------------
module caleidoscope_sequencer #(
  parameter int unsigned V_ACTIVE    = 480,
  parameter logic [15:0] LIMIT_MASK  = 16'h00FF,
  parameter logic [23:0] CONST_BASE  = 24'h200,
  parameter int unsigned CONST_SHIFT = 3
) (
  input  logic        CLK_25MHz,
  input  logic        RESET,
  input  logic        VBLANK,
  input  logic        HBLANK,
  input  logic [8:0]  CURY,
  input  logic [2:0]  SWITCH,
  output logic [15:0] TIME,
  output logic [23:0] TIME_CONST,
  output logic [8:0]  NEW_Y,
  output logic [15:0] Y_SQUARED,
  output logic        LINE_READY,
  output logic        FRAME_TICK,
  output logic        BUSY
);

  localparam logic [9:0] FOLD_POINT = 10'(V_ACTIVE / 2);
  localparam logic [9:0] LINE_LIMIT = 10'(V_ACTIVE);
  localparam logic [9:0] LAST_LINE  = 10'(V_ACTIVE - 1);
  localparam logic [3:0] LAST_ITER  = 4'd8;  // nine iterations: 0..8

  typedef enum logic [1:0] {F_IDLE, F_TIME, F_TRI, F_CONST} frame_state_t;
  typedef enum logic       {L_IDLE, L_MUL}                  line_state_t;

  // --------------------------------------------------------------------------
  // Blank edge detection. bit 0 = VBLANK, bit 1 = HBLANK. The history register
  // resets high, so a blank that is already high at reset produces no edge.
  // --------------------------------------------------------------------------
  logic [1:0] blank_now;
  logic [1:0] blank_prev_reg;
  logic [1:0] blank_rise;
  logic       vblank_rise;
  logic       hblank_rise;

  assign blank_now = {HBLANK, VBLANK};

  always_ff @(posedge CLK_25MHz) begin
    if (RESET) blank_prev_reg <= 2'b11;
    else       blank_prev_reg <= blank_now;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      assign blank_rise[gi] = blank_now[gi] & ~blank_prev_reg[gi];
    end
  endgenerate

  assign vblank_rise = blank_rise[0];
  assign hblank_rise = blank_rise[1];

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  frame_state_t frame_state_reg, frame_state_next;
  logic [15:0]  time_reg, time_next;
  logic [15:0]  time_tri_reg, time_tri_next;
  logic [23:0]  time_const_reg, time_const_next;
  logic         frame_tick_reg, frame_tick_next;
  logic         stop_reg, stop_next;
  logic [1:0]   speed_mode;      // [0] 2x speed, [1] unlimited
  logic [15:0]  time_sum;
  logic [23:0]  time_tri_ext;

`ifdef CALEIDOSCOPE_AUTOPLAY_EN
  logic [7:0] auto_cnt_reg, auto_cnt_next;
  assign speed_mode = auto_cnt_reg[7:6];
`else
  logic [1:0] mode_reg, mode_next;
  assign speed_mode = mode_reg;
`endif

  assign time_sum     = time_reg + (speed_mode[0] ? 16'd2 : 16'd1);
  assign time_tri_ext = {8'h00, time_tri_reg};

  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      frame_state_reg <= F_IDLE;
      time_reg        <= 16'd0;
      time_tri_reg    <= 16'd0;
      time_const_reg  <= CONST_BASE;
      frame_tick_reg  <= 1'b0;
      stop_reg        <= 1'b0;
`ifdef CALEIDOSCOPE_AUTOPLAY_EN
      auto_cnt_reg    <= 8'd0;
`else
      mode_reg        <= 2'b00;
`endif
    end else begin
      frame_state_reg <= frame_state_next;
      time_reg        <= time_next;
      time_tri_reg    <= time_tri_next;
      time_const_reg  <= time_const_next;
      frame_tick_reg  <= frame_tick_next;
      stop_reg        <= stop_next;
`ifdef CALEIDOSCOPE_AUTOPLAY_EN
      auto_cnt_reg    <= auto_cnt_next;
`else
      mode_reg        <= mode_next;
`endif
    end
  end

  always_comb begin
    frame_state_next = frame_state_reg;
    time_next        = time_reg;
    time_tri_next    = time_tri_reg;
    time_const_next  = time_const_reg;
    frame_tick_next  = 1'b0;
    stop_next        = stop_reg;
`ifdef CALEIDOSCOPE_AUTOPLAY_EN
    auto_cnt_next    = auto_cnt_reg;
`else
    mode_next        = mode_reg;
`endif
    case (frame_state_reg)
      F_IDLE: begin
        // A VBLANK edge seen in any other state is ignored.
        if (vblank_rise) begin
          stop_next = SWITCH[0];
`ifndef CALEIDOSCOPE_AUTOPLAY_EN
          mode_next = SWITCH[2:1];
`endif
          frame_state_next = F_TIME;
        end
      end
      F_TIME: begin
        if (!stop_reg) begin
          time_next = speed_mode[1] ? time_sum : (time_sum & LIMIT_MASK);
`ifdef CALEIDOSCOPE_AUTOPLAY_EN
          auto_cnt_next = auto_cnt_reg + 8'd1;
`endif
        end
        frame_state_next = F_TRI;
      end
      F_TRI: begin
        time_tri_next    = (time_reg >= 16'h0080) ? (16'h00FF - time_reg) : time_reg;
        frame_state_next = F_CONST;
      end
      F_CONST: begin
        time_const_next  = CONST_BASE - (time_tri_ext << CONST_SHIFT);
        // The tick is registered so that it appears together with the new TIME_CONST.
        frame_tick_next  = 1'b1;
        frame_state_next = F_IDLE;
      end
      default: frame_state_next = F_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Line FSM with an iterative shift-add squarer
  // --------------------------------------------------------------------------
  line_state_t line_state_reg, line_state_next;
  logic [8:0]  op_y_reg, op_y_next;
  logic [17:0] mcand_reg, mcand_next;    // multiplicand, shifted left per step
  logic [8:0]  mplier_reg, mplier_next;  // multiplier, consumed LSB first
  logic [17:0] acc_reg, acc_next;
  logic [3:0]  iter_reg, iter_next;
  logic [8:0]  new_y_reg, new_y_next;
  logic [15:0] y_sq_reg, y_sq_next;
  logic        line_ready_reg, line_ready_next;
  logic        busy_reg, busy_next;
  logic [8:0]  fold_y;
  logic [17:0] acc_sum;

  // Mirror the lower half of the screen onto the upper half. Lines below the
  // visible area map to 0.
  always_comb begin
    fold_y = 9'd0;
    if ({1'b0, CURY} < FOLD_POINT)      fold_y = CURY;
    else if ({1'b0, CURY} < LINE_LIMIT) fold_y = 9'(LAST_LINE - {1'b0, CURY});
  end

  assign acc_sum = acc_reg + (mplier_reg[0] ? mcand_reg : 18'd0);

  always_ff @(posedge CLK_25MHz) begin
    if (RESET) begin
      line_state_reg <= L_IDLE;
      op_y_reg       <= 9'd0;
      mcand_reg      <= 18'd0;
      mplier_reg     <= 9'd0;
      acc_reg        <= 18'd0;
      iter_reg       <= 4'd0;
      new_y_reg      <= 9'd0;
      y_sq_reg       <= 16'd0;
      line_ready_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      line_state_reg <= line_state_next;
      op_y_reg       <= op_y_next;
      mcand_reg      <= mcand_next;
      mplier_reg     <= mplier_next;
      acc_reg        <= acc_next;
      iter_reg       <= iter_next;
      new_y_reg      <= new_y_next;
      y_sq_reg       <= y_sq_next;
      line_ready_reg <= line_ready_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    line_state_next = line_state_reg;
    op_y_next       = op_y_reg;
    mcand_next      = mcand_reg;
    mplier_next     = mplier_reg;
    acc_next        = acc_reg;
    iter_next       = iter_reg;
    new_y_next      = new_y_reg;
    y_sq_next       = y_sq_reg;
    line_ready_next = line_ready_reg;
    busy_next       = busy_reg;
    if (hblank_rise) begin
      // This branch also restarts a multiply that is already running. The
      // partial result of that multiply is discarded.
      line_state_next = L_MUL;
      op_y_next       = fold_y;
      mcand_next      = {9'd0, fold_y};
      mplier_next     = fold_y;
      acc_next        = 18'd0;
      iter_next       = 4'd0;
      line_ready_next = 1'b0;
      busy_next       = 1'b1;
    end else if (line_state_reg == L_MUL) begin
      acc_next    = acc_sum;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      iter_next   = iter_reg + 4'd1;
      if (iter_reg == LAST_ITER) begin
        new_y_next      = op_y_reg;
        y_sq_next       = acc_sum[15:0];
        line_ready_next = 1'b1;
        busy_next       = 1'b0;
        line_state_next = L_IDLE;
      end
    end
  end

  assign TIME       = time_reg;
  assign TIME_CONST = time_const_reg;
  assign NEW_Y      = new_y_reg;
  assign Y_SQUARED  = y_sq_reg;
  assign LINE_READY = line_ready_reg;
  assign FRAME_TICK = frame_tick_reg;
  assign BUSY       = busy_reg;

endmodule

// File: tb/tb_caleidoscope_sequencer.sv
// Testbench for caleidoscope_sequencer.
// A small reference model computes the expected values. They are pushed to a
// scoreboard when stimulus is driven, then popped and compared when
// FRAME_TICK or LINE_READY is observed.
`timescale 1ns/1ps
module tb_caleidoscope_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblank;
  logic        hblank;
  logic [8:0]  cury;
  logic [2:0]  sw;
  logic [15:0] time_o;
  logic [23:0] time_const_o;
  logic [8:0]  new_y_o;
  logic [15:0] y_sq_o;
  logic        line_ready_o;
  logic        frame_tick_o;
  logic        busy_o;

  always #5 clk = ~clk;

  caleidoscope_sequencer dut (
    .CLK_25MHz (clk),
    .RESET     (rst),
    .VBLANK    (vblank),
    .HBLANK    (hblank),
    .CURY      (cury),
    .SWITCH    (sw),
    .TIME      (time_o),
    .TIME_CONST(time_const_o),
    .NEW_Y     (new_y_o),
    .Y_SQUARED (y_sq_o),
    .LINE_READY(line_ready_o),
    .FRAME_TICK(frame_tick_o),
    .BUSY      (busy_o)
  );

  typedef struct {logic [15:0] t; logic [23:0] c;} frame_exp_t;
  typedef struct {logic [8:0]  y; logic [15:0] sq;} line_exp_t;

  frame_exp_t  frame_q[$];
  line_exp_t   line_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_time;
  logic [7:0]  m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] fold(input int y);
    if (y < 240)      return 9'(y);
    else if (y < 480) return 9'(479 - y);
    else              return 9'd0;
  endfunction

  task automatic push_frame(input logic [2:0] s);
    logic [1:0]  mode;
    logic [15:0] tri_v;
    if (!s[0]) begin
`ifdef CALEIDOSCOPE_AUTOPLAY_EN
      mode  = m_cnt[7:6];
      m_cnt = m_cnt + 8'd1;
`else
      mode = s[2:1];
`endif
      m_time = m_time + (mode[0] ? 16'd2 : 16'd1);
      if (!mode[1]) m_time = m_time & 16'h00FF;
    end
    tri_v = (m_time >= 16'h0080) ? (16'h00FF - m_time) : m_time;
    frame_q.push_back('{m_time, 24'h200 - ({8'h00, tri_v} << 3)});
  endtask

  task automatic push_line(input int c);
    logic [15:0] yy;
    yy = {7'd0, fold(c)};
    line_q.push_back('{fold(c), yy * yy});
  endtask

  // Edge k=1 is the edge that samples the blank rise.
  task automatic run(input bit want_frame, input bit want_line);
    bit         fp;
    bit         lp;
    int         busy_cnt;
    frame_exp_t fe;
    line_exp_t  le;
    fp = want_frame;
    lp = want_line;
    busy_cnt = 0;
    for (int k = 1; k <= 16 && (fp || lp); k++) begin
      tick();
      if (k == 1) begin
        vblank = 1'b0;
        hblank = 1'b0;
        if (want_line) begin
          check("busy_on_rise", busy_o, 1);
          check("ready_drop", line_ready_o, 0);
        end
      end
      if (lp && busy_o) busy_cnt++;
      if (fp && frame_tick_o) begin
        check("tick_latency", k, 4);
        fe = frame_q.pop_front();
        check("time", time_o, fe.t);
        check("time_const", time_const_o, fe.c);
        fp = 1'b0;
      end
      if (lp && line_ready_o) begin
        check("line_latency", k, 10);
        check("busy_cycles", busy_cnt, 9);
        le = line_q.pop_front();
        check("new_y", new_y_o, le.y);
        check("y_squared", y_sq_o, le.sq);
        lp = 1'b0;
      end
    end
    if (want_frame) check("frame_timeout", fp, 0);
    if (want_line)  check("line_timeout", lp, 0);
    tick();
    if (want_frame) check("tick_width", frame_tick_o, 0);
  endtask

  task automatic frame(input logic [2:0] s);
    sw = s;
    vblank = 1'b1;
    push_frame(s);
    run(1'b1, 1'b0);
  endtask

  task automatic line(input int c);
    cury = 9'(c);
    hblank = 1'b1;
    push_line(c);
    run(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vblank = 1'b0;
    hblank = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_time = 16'd0;
    m_cnt  = 8'd0;
    frame_q.delete();
    line_q.delete();
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_time"},  time_o, 16'd0);
    check({tag, "_const"}, time_const_o, 24'h200);
    check({tag, "_newy"},  new_y_o, 9'd0);
    check({tag, "_ysq"},   y_sq_o, 16'd0);
    check({tag, "_ready"}, line_ready_o, 0);
    check({tag, "_tick"},  frame_tick_o, 0);
    check({tag, "_busy"},  busy_o, 0);
  endtask

  logic [15:0] t0;
  int          spurious;

  initial begin
    rst = 1'b1; vblank = 1'b0; hblank = 1'b0; cury = 9'd0; sw = 3'b000;
    m_time = 16'd0; m_cnt = 8'd0;

    // 1: reset values, then three frames at normal speed
    do_reset();
    check_reset_values("reset");
    for (int i = 0; i < 3; i++) frame(3'b000);
    check("t1_time", time_o, 16'd3);
    check("t1_const", time_const_o, 24'h1E8);

    // 2: 2x speed in limited mode, wrap at 0xFF, and the triangle fold at 0x90
    do_reset();
    for (int i = 0; i < 127; i++) frame(3'b010);
`ifndef CALEIDOSCOPE_AUTOPLAY_EN
    check("t2_pre_wrap", time_o, 16'h00FE);
`endif
    frame(3'b010);
`ifndef CALEIDOSCOPE_AUTOPLAY_EN
    check("t2_wrap", time_o, 16'h0000);
`endif
    for (int i = 0; i < 72; i++) frame(3'b010);
`ifndef CALEIDOSCOPE_AUTOPLAY_EN
    check("t2_time90", time_o, 16'h0090);
    check("t2_const90", time_const_o, 24'hFFFE88);
`endif

    // 3: row folding and squaring
    line(240);
    line(479);
    line(500);
    line(239);
    check("t3_newy", new_y_o, 9'd239);
    check("t3_ysq", y_sq_o, 16'hDF21);

    // 4: restart of a running multiply by a second HBLANK rise at edge 5
    cury = 9'd300;
    hblank = 1'b1;
    push_line(300);
    tick();
    hblank = 1'b0;
    tick();
    tick();
    tick();
    check("t4_held_newy", new_y_o, 9'd239);
    check("t4_held_ysq", y_sq_o, 16'hDF21);
    cury = 9'd10;
    hblank = 1'b1;
    void'(line_q.pop_back());
    push_line(10);
    run(1'b0, 1'b1);
    check("t4_ysq", y_sq_o, 16'd100);

    // 5: simultaneous VBLANK and HBLANK rises while time is stopped
    t0 = time_o;
    sw = 3'b001;
    cury = 9'd50;
    vblank = 1'b1;
    hblank = 1'b1;
    push_frame(3'b001);
    push_line(50);
    run(1'b1, 1'b1);
    check("t5_time_held", time_o, t0);

    // 5b: reset while both FSMs are in progress
    sw = 3'b000;
    cury = 9'd200;
    vblank = 1'b1;
    hblank = 1'b1;
    tick();
    vblank = 1'b0;
    hblank = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("midrst");
    rst = 1'b0;
    m_time = 16'd0;
    m_cnt  = 8'd0;
    frame_q.delete();
    line_q.delete();
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (frame_tick_o || line_ready_o || busy_o) spurious++;
    end
    check("midrst_quiet", spurious, 0);
    line(77);
    frame(3'b000);

`ifdef CALEIDOSCOPE_AUTOPLAY_EN
    // 6: autoplay steps through the speed modes
    do_reset();
    for (int i = 0; i < 64; i++) frame(3'b000);
    check("t6_time64", time_o, 16'd64);
    for (int i = 0; i < 4; i++) frame(3'b000);
    check("t6_time72", time_o, 16'd72);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
